// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD time-of-day clock with RUN and hour/minute/second set modes
module time_keeper #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] mode,
  output logic       day_wrap
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} mode_t;

  mode_t         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hr_t_d, hr_o_d, min_t_d, min_o_d, sec_t_d, sec_o_d;
  logic          day_wrap_d;
  logic          one_btn;

  assign mode    = state_q;
  assign one_btn = inc_btn ^ dec_btn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      presc_q  <= '0;
      hr_t     <= 4'd0;
      hr_o     <= 4'd0;
      min_t    <= 4'd0;
      min_o    <= 4'd0;
      sec_t    <= 4'd0;
      sec_o    <= 4'd0;
      day_wrap <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hr_t     <= hr_t_d;
      hr_o     <= hr_o_d;
      min_t    <= min_t_d;
      min_o    <= min_o_d;
      sec_t    <= sec_t_d;
      sec_o    <= sec_o_d;
      day_wrap <= day_wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    hr_t_d     = hr_t;
    hr_o_d     = hr_o;
    min_t_d    = min_t;
    min_o_d    = min_o;
    sec_t_d    = sec_t;
    sec_o_d    = sec_o;
    day_wrap_d = 1'b0;

    unique case (state_q)
      RUN: begin
        // A tick due on the same edge as mode_btn still lands before entering SET_HR.
        if (presc_q == LAST) begin
          presc_d = '0;
          if (sec_o != 4'd9) sec_o_d = sec_o + 4'd1;
          else begin
            sec_o_d = 4'd0;
            if (sec_t != 4'd5) sec_t_d = sec_t + 4'd1;
            else begin
              sec_t_d = 4'd0;
              if (min_o != 4'd9) min_o_d = min_o + 4'd1;
              else begin
                min_o_d = 4'd0;
                if (min_t != 4'd5) min_t_d = min_t + 4'd1;
                else begin
                  min_t_d = 4'd0;
                  if (hr_t == 4'd2 && hr_o == 4'd3) begin
                    hr_t_d     = 4'd0;
                    hr_o_d     = 4'd0;
                    day_wrap_d = 1'b1;
                  end else if (hr_o == 4'd9) begin
                    hr_o_d = 4'd0;
                    hr_t_d = hr_t + 4'd1;
                  end else begin
                    hr_o_d = hr_o + 4'd1;
                  end
                end
              end
            end
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (mode_btn) begin
          state_d = SET_HR;
          presc_d = '0;
        end
      end

      SET_HR: begin
        if (mode_btn) state_d = SET_MIN;
        else if (one_btn && inc_btn) begin
          if (hr_t == 4'd2 && hr_o == 4'd3) begin
            hr_t_d = 4'd0;
            hr_o_d = 4'd0;
          end else if (hr_o == 4'd9) begin
            hr_o_d = 4'd0;
            hr_t_d = hr_t + 4'd1;
          end else hr_o_d = hr_o + 4'd1;
        end else if (one_btn) begin
          if (hr_t == 4'd0 && hr_o == 4'd0) begin
            hr_t_d = 4'd2;
            hr_o_d = 4'd3;
          end else if (hr_o == 4'd0) begin
            hr_o_d = 4'd9;
            hr_t_d = hr_t - 4'd1;
          end else hr_o_d = hr_o - 4'd1;
        end
      end

      SET_MIN: begin
        // Minutes wrap within the field; hours never see a carry or borrow here.
        if (mode_btn) state_d = SET_SEC;
        else if (one_btn && inc_btn) begin
          if (min_o == 4'd9) begin
            min_o_d = 4'd0;
            min_t_d = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
          end else min_o_d = min_o + 4'd1;
        end else if (one_btn) begin
          if (min_o == 4'd0) begin
            min_o_d = 4'd9;
            min_t_d = (min_t == 4'd0) ? 4'd5 : min_t - 4'd1;
          end else min_o_d = min_o - 4'd1;
        end
      end

      SET_SEC: begin
        if (mode_btn) begin
          state_d = RUN;
          presc_d = '0;
        end else if (one_btn) begin
          sec_t_d = 4'd0;
          sec_o_d = 4'd0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - scoreboard bench for time_keeper against a seconds-of-day model
module tb_time_keeper;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic [1:0] mode;
  logic       day_wrap;

  always #5 clk = ~clk;

  time_keeper #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .mode(mode), .day_wrap(day_wrap)
  );

  typedef struct packed {
    logic [31:0] id;
    logic [26:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference model: time as seconds since midnight, mode as 0..3, cycles spent in RUN since last second.
  int   m_mode = 0;
  int   m_tod = 0;
  int   m_cnt = 0;
  bit   m_wrap = 1'b0;

  function automatic logic [26:0] expected();
    int h, mi, s;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    return {2'(m_mode), m_wrap, 4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void model_step(bit r, bit m, bit i, bit d);
    int h, mi, s;
    m_wrap = 1'b0;
    if (r) begin
      m_mode = 0; m_tod = 0; m_cnt = 0;
      return;
    end
    if (m_mode == 0) begin
      if (m_cnt == TPS - 1) begin
        m_cnt  = 0;
        m_tod  = (m_tod + 1) % 86400;
        m_wrap = (m_tod == 0);
      end else m_cnt++;
      if (m) begin m_mode = 1; m_cnt = 0; end
    end else if (m) begin
      m_mode = (m_mode + 1) % 4;
      m_cnt  = 0;
    end else if (i != d) begin
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      s  = m_tod % 60;
      case (m_mode)
        1: h  = i ? (h + 1) % 24 : (h + 23) % 24;
        2: mi = i ? (mi + 1) % 60 : (mi + 59) % 60;
        default: s = 0;
      endcase
      m_tod = h * 3600 + mi * 60 + s;
    end
  endfunction

  task automatic step(input bit r, input bit m, input bit i, input bit d);
    exp_t e;
    @(negedge clk);
    reset = r; mode_btn = m; inc_btn = i; dec_btn = d;
    model_step(r, m, i, d);
    e.id = 32'(step_no);
    e.v  = expected();
    sb.push_back(e);
    step_no++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [26:0] got;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {mode, day_wrap, hr_t, hr_o, min_t, min_o, sec_t, sec_o};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL cycle_%0d got mode=%0d wrap=%0b %h%h:%h%h:%h%h required mode=%0d wrap=%0b %h%h:%h%h:%h%h",
                 e.id, got[26:25], got[24], got[23:20], got[19:16], got[15:12], got[11:8], got[7:4], got[3:0],
                 e.v[26:25], e.v[24], e.v[23:20], e.v[19:16], e.v[15:12], e.v[11:8], e.v[7:4], e.v[3:0]);
      end
    end
  end

  initial begin
    // Reset then free run to 00:00:01 and 00:00:10.
    step(1, 0, 0, 0);
    idle(40);

    // Preset 23:59 (seconds at 10), run through the day rollover.
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(200);

    // Hour and minute wrap in both directions.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);

    // Simultaneous inc/dec, then mode_btn with inc.
    step(0, 0, 1, 1);
    step(0, 1, 1, 0);

    // Clear seconds at 37 and check the restart latency into RUN.
    step(1, 0, 0, 0);
    idle(148);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(6);

    // Build 12:34:56 and reset while in SET_MIN.
    step(1, 0, 0, 0);
    idle(224);
    step(0, 1, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 34; k++) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    idle(3);

    // Random traffic including reset mid-count and mid-set.
    for (int k = 0; k < 2000; k++)
      step($urandom_range(199) == 0, $urandom_range(15) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, clk cycles per second; legal range >= 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mode_btn  input  1  one-cycle pulse; advances the mode state machine.
REQ-005 SHALL have port inc_btn  input  1  one-cycle pulse; increments the selected field in a set mode.
REQ-006 SHALL have port dec_btn  input  1  one-cycle pulse; decrements the selected field in a set mode.
REQ-007 SHALL have ports hr_t, hr_o, min_t, min_o, sec_t, sec_o  output  4 each  registered BCD digits (tens/ones) of hours, minutes, seconds.
REQ-008 SHALL have port mode  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
REQ-009 SHALL have port day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover in RUN.

Function
REQ-010 SHALL keep a prescaler counting 0..TICKS_PER_SEC-1 in RUN only; it holds at 0 in all set states.
REQ-011 SHALL, in RUN, advance time by one second at the edge where prescaler == TICKS_PER_SEC-1, with the prescaler returning to 0 on that same edge (one second = exactly TICKS_PER_SEC cycles).
REQ-012 SHALL advance with BCD carry: sec_o 9->0 carries to sec_t; sec 59->00 carries to minutes; min 59->00 carries to hours; hr 23->00.
REQ-013 SHALL pulse day_wrap high for exactly the one cycle after the 23:59:59 -> 00:00:00 edge; day_wrap is never asserted outside RUN.
REQ-014 SHALL never hold an illegal BCD digit or value (sec/min > 59, hr > 23) on any output.
REQ-015 SHALL step mode on mode_btn: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
REQ-016 SHALL, in SET_HR, on inc_btn step hours +1 with 23 -> 00; on dec_btn step hours -1 with 00 -> 23; minutes and seconds unchanged.
REQ-017 SHALL, in SET_MIN, on inc_btn step minutes +1 with 59 -> 00; on dec_btn step minutes -1 with 00 -> 59; no carry/borrow into hours.
REQ-018 SHALL, in SET_SEC, clear seconds to 00 on inc_btn or dec_btn.
REQ-019 SHALL apply field changes on the edge the button is sampled (1-cycle latency to outputs).
REQ-020 SHALL ignore inc_btn and dec_btn in RUN.
REQ-021 SHALL ignore inc_btn and dec_btn asserted in the same cycle (no change).
REQ-022 SHALL, if mode_btn coincides with inc_btn or dec_btn, perform only the mode transition (the button is ignored).
REQ-023 SHALL restart counting on SET_SEC -> RUN with the prescaler at 0, so the first RUN advance occurs TICKS_PER_SEC cycles after the transition edge.
REQ-024 SHALL freeze time in all set states (no RUN advance, no day_wrap).

Reset
REQ-025 SHALL, when reset is high at a rising edge, set all digits to 0 (00:00:00), mode to RUN, prescaler to 0, and day_wrap to 0.
REQ-026 SHALL give reset priority over every other input, including mid-count and mid-set-mode; the first advance after release occurs TICKS_PER_SEC cycles after the first non-reset edge.

Verification (TICKS_PER_SEC = 4)
REQ-027 SHALL cover: reset, then 4 cycles idle -> 00:00:01; 40 cycles -> 00:00:10 with sec_t=1, sec_o=0.
REQ-028 SHALL cover: preset 23:59:59 via set modes, return to RUN, 4 cycles -> 00:00:00 and day_wrap high for exactly 1 cycle.
REQ-029 SHALL cover: SET_HR at 00, dec_btn -> hr 23; inc_btn -> 00; SET_MIN at 59, inc_btn -> min 00 and hours unchanged.
REQ-030 SHALL cover: set state, inc_btn and dec_btn asserted together -> no change; mode_btn with inc_btn -> mode advances, field unchanged.
REQ-031 SHALL cover: SET_SEC at sec 37, dec_btn -> sec 00; mode_btn -> RUN, then no advance for 3 cycles and 00:xx:01 reached on the 4th cycle.
REQ-032 SHALL cover: reset asserted in SET_MIN at 12:34:56 -> next cycle 00:00:00, mode 0.
